window_regfile: RTL and testbench
=================================

WINDOW_REGFILE -- requirements
Module: window_regfile

Interface
REQ-001 SHALL have parameter DW, default 8, PE result byte width.
REQ-002 SHALL have parameter DEPTH, default 32, buffer entries; power of two, at least 2*LANES.
REQ-003 SHALL have parameter LANES, default 8, maximum window size and output lane count.
REQ-004 SHALL have ports:
- clk_cal  in  1  sole clock; all state on rising edge.
- rst_cal  in  1  asynchronous, active-high reset.
- start  in  1  pulse; latch win_p/win_s and begin a layer.
- win_p  in  4  window size P, legal 1..LANES.
- win_s  in  3  stride S, legal 1..P.
- pad_en  in  1  zero-pad a trailing partial window at layer end; sampled with start.
- layer_end  in  1  pulse; no more input this layer.
- in_data  in  DW  PE result byte.
- in_vld  in  1  input valid.
- in_rdy  out  1  input ready.
- out_data  out  LANES*DW  window; lane i at bits [i*DW +: DW], lane 0 oldest.
- out_vld  out  1  window valid.
- out_rdy  in  1  downstream ready.
- out_last  out  1  final window of layer; qualified by out_vld.
- layer_done  out  1  one-cycle pulse at layer completion.
- cfg_err  out  1  one-cycle pulse on illegal start config.
- count  out  log2(DEPTH)+1  current buffer occupancy.

Function
REQ-005 SHALL implement FSM IDLE, RUN, FLUSH, CLEAR.
REQ-006 IDLE: start with legal P/S SHALL latch P, S, pad_en and go to RUN; illegal config (P=0, P>LANES, S=0, S>P) SHALL pulse cfg_err next cycle and stay IDLE.
REQ-007 Buffer SHALL be circular: write pointer, read pointer, count; pointers SHALL wrap modulo DEPTH.
REQ-008 in_rdy SHALL equal (state==RUN && count<DEPTH); a byte SHALL be written on in_vld && in_rdy.
REQ-009 Output stage SHALL be one register; it SHALL load when (!out_vld || out_rdy) && count>=P.
REQ-010 On load: lane i = buf[(rptr+i) mod DEPTH] for i<P; lanes i>=P SHALL be zero; rptr += S; count -= S.
REQ-011 On simultaneous write and load, count SHALL update to count+1-S in one cycle.
REQ-012 Latency: the byte completing a window, written at edge k, SHALL make out_vld high after edge k+1 (if the output register is free).
REQ-013 out_vld/out_data/out_last SHALL hold stable while out_vld && !out_rdy.
REQ-014 layer_end in RUN SHALL move to FLUSH; in_rdy low from the next cycle; a byte accepted in the same cycle as layer_end SHALL be kept.
REQ-015 FLUSH SHALL keep emitting full windows while count>=P.
REQ-016 FLUSH with count<P: if pad_en && count>0 && (no window emitted this layer || count>P-S), SHALL load one window of the count remaining bytes, zero in lanes >= count.
REQ-017 The final window loaded in FLUSH SHALL carry out_last=1; all others 0.
REQ-018 FLUSH SHALL go to CLEAR once no further window is due and out_vld is low (last window accepted).
REQ-019 CLEAR SHALL zero pointers and count, drop residual bytes, pulse layer_done, then go to IDLE.
REQ-020 A layer with no emitted window SHALL still pulse layer_done with out_last never asserted.
REQ-021 start outside IDLE and layer_end outside RUN SHALL be ignored.

Reset
REQ-022 rst_cal SHALL asynchronously force IDLE, pointers, count, and every output to 0 (out_data all zero), including mid-transfer.
REQ-023 Buffer contents need not be reset.

Verification
REQ-024 P=4,S=2, bytes 01..08, out_rdy=1 -> windows {01,02,03,04},{03,04,05,06},{05,06,07,08}; lanes 4-7 zero; out_last on the third window after layer_end.
REQ-025 P=8,S=4, pad_en=1, bytes 01..0A, layer_end -> {01..08}, then {05..0A,00,00} with out_last=1, then layer_done.
REQ-026 P=2,S=2, DEPTH=32, 40 bytes with out_rdy=0 for 50 cycles -> in_rdy low at count=32; after out_rdy=1, all 20 windows in order; pointer wrap correct.
REQ-027 start with win_p=9 (LANES=8) or win_s=0 -> cfg_err pulse, state IDLE, in_rdy=0.
REQ-028 rst_cal during stalled out_vld with count=12 -> all outputs 0, count 0; a new layer then runs normally.

Source files
------------

// File: rtl/window_regfile.sv
// Sliding-window register file: buffers PE result bytes in a circular store and
// emits P-byte windows advancing by stride S, with optional zero-padded tail.
module window_regfile #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned LANES = 8
) (
  input  logic                   clk_cal,
  input  logic                   rst_cal,
  input  logic                   start,
  input  logic [3:0]             win_p,
  input  logic [2:0]             win_s,
  input  logic                   pad_en,
  input  logic                   layer_end,
  input  logic [DW-1:0]          in_data,
  input  logic                   in_vld,
  output logic                   in_rdy,
  output logic [LANES*DW-1:0]    out_data,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic                   out_last,
  output logic                   layer_done,
  output logic                   cfg_err,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [3:0]    LANES_P = 4'(LANES);
  localparam logic [CW-1:0] FULL    = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, CLEAR} state_t;

  state_t              state_q, state_d;
  logic [3:0]          p_q, p_d;
  logic [2:0]          s_q, s_d;
  logic                pad_q, pad_d;
  logic                emitted_q, emitted_d;
  logic [AW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]       count_d;
  logic [LANES*DW-1:0] out_data_d;
  logic                out_vld_d, out_last_d, layer_done_d, cfg_err_d, in_rdy_d;
  logic [DW-1:0]       mem [DEPTH];

  logic                cfg_ok, wr, active, ld_free, full_ok, pad_due, due, due_after;
  logic                ld_full, ld_pad;
  logic [CW-1:0]       p_cw, s_cw, gap_cw, cnt_after, nlanes;

  assign cfg_ok = (win_p != 4'd0) && (win_p <= LANES_P) &&
                  (win_s != 3'd0) && ({1'b0, win_s} <= win_p);

  // Window bookkeeping: a padded tail is only worth emitting if it holds unseen bytes.
  assign p_cw      = CW'(p_q);
  assign s_cw      = CW'(s_q);
  assign gap_cw    = CW'(p_q - {1'b0, s_q});
  assign wr        = in_vld && in_rdy;
  assign active    = (state_q == RUN) || (state_q == FLUSH);
  assign ld_free   = !out_vld || out_rdy;
  assign full_ok   = count >= p_cw;
  assign pad_due   = pad_q && (count != '0) && (!emitted_q || count > gap_cw);
  assign due       = full_ok || pad_due;
  assign cnt_after = count - s_cw;
  assign due_after = (cnt_after >= p_cw) ||
                     (pad_q && (cnt_after != '0) && (cnt_after > gap_cw));
  assign ld_full   = active && ld_free && full_ok;
  assign ld_pad    = (state_q == FLUSH) && ld_free && !full_ok && pad_due;
  assign nlanes    = ld_full ? p_cw : count;

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && cfg_ok) state_d = RUN;
      RUN:     if (layer_end) state_d = FLUSH;
      FLUSH:   if (!due && !out_vld) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    p_d          = p_q;
    s_d          = s_q;
    pad_d        = pad_q;
    emitted_d    = emitted_q;
    wptr_d       = wptr_q + AW'(wr);
    rptr_d       = rptr_q;
    count_d      = count + CW'(wr);
    out_data_d   = out_data;
    out_vld_d    = out_vld && !out_rdy;
    out_last_d   = out_last;
    layer_done_d = 1'b0;
    cfg_err_d    = 1'b0;

    if (ld_full || ld_pad) begin
      for (int i = 0; i < LANES; i++) begin
        out_data_d[i*DW +: DW] = (CW'(i) < nlanes) ? mem[rptr_q + AW'(i)] : '0;
      end
      out_vld_d = 1'b1;
      emitted_d = 1'b1;
      if (ld_full) begin
        rptr_d     = rptr_q + AW'(s_q);
        count_d    = count + CW'(wr) - s_cw;
        out_last_d = (state_q == FLUSH) && !due_after;
      end else begin
        rptr_d     = rptr_q + AW'(count);
        count_d    = '0;
        out_last_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (cfg_ok) begin
            p_d       = win_p;
            s_d       = win_s;
            pad_d     = pad_en;
            emitted_d = 1'b0;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      CLEAR: begin
        wptr_d       = '0;
        rptr_d       = '0;
        count_d      = '0;
        layer_done_d = 1'b1;
      end
      default: ;
    endcase

    in_rdy_d = (state_d == RUN) && (count_d < FULL);
  end

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) begin
      p_q        <= '0;
      s_q        <= '0;
      pad_q      <= 1'b0;
      emitted_q  <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count      <= '0;
      out_data   <= '0;
      out_vld    <= 1'b0;
      out_last   <= 1'b0;
      layer_done <= 1'b0;
      cfg_err    <= 1'b0;
      in_rdy     <= 1'b0;
    end else begin
      p_q        <= p_d;
      s_q        <= s_d;
      pad_q      <= pad_d;
      emitted_q  <= emitted_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count      <= count_d;
      out_data   <= out_data_d;
      out_vld    <= out_vld_d;
      out_last   <= out_last_d;
      layer_done <= layer_done_d;
      cfg_err    <= cfg_err_d;
      in_rdy     <= in_rdy_d;
    end
  end

  // Byte store; contents are don't-care until written.
  always_ff @(posedge clk_cal) begin
    if (wr) mem[wptr_q] <= in_data;
  end

endmodule

// File: tb/tb_window_regfile.sv
// Self-checking bench for window_regfile: config table, directed corner cases and
// randomized layers checked against a list-based window model.
module tb_window_regfile;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned LANES = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic                clk_cal = 1'b0;
  logic                rst_cal;
  logic                start, pad_en, layer_end, in_vld, in_rdy, out_vld, out_rdy;
  logic                out_last, layer_done, cfg_err;
  logic [3:0]          win_p;
  logic [2:0]          win_s;
  logic [DW-1:0]       in_data;
  logic [LANES*DW-1:0] out_data;
  logic [CW-1:0]       count;

  always #5 clk_cal = ~clk_cal;

  window_regfile #(.DW(DW), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk_cal(clk_cal), .rst_cal(rst_cal), .start(start), .win_p(win_p), .win_s(win_s),
    .pad_en(pad_en), .layer_end(layer_end), .in_data(in_data), .in_vld(in_vld),
    .in_rdy(in_rdy), .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_last(out_last), .layer_done(layer_done), .cfg_err(cfg_err), .count(count)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  sent_q[$];
  logic [63:0] exp_d[$];
  int          exp_l[$];   // 0/1 required out_last, 2 = timing dependent
  logic [63:0] got_d[$];
  logic        got_l[$];

  typedef struct {
    logic [3:0] p;
    logic [2:0] s;
    logic       err;
  } cfg_vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] win_of(input int st, input int n);
    logic [63:0] w = '0;
    for (int i = 0; i < n; i++) w[i*8 +: 8] = sent_q[st+i];
    return w;
  endfunction

  function automatic logic [63:0] got_at(input int i);
    return (i < got_d.size()) ? got_d[i] : 64'hdead_beef_dead_beef;
  endfunction

  // Windows start every S bytes while P bytes remain; a tail shorter than P is
  // padded only when enabled and it contains bytes no earlier window covered.
  task automatic build_exp(input int p, input int s, input int pad);
    int n, nwin, b, rem;
    n = sent_q.size();
    exp_d.delete();
    exp_l.delete();
    nwin = (n >= p) ? (n - p) / s + 1 : 0;
    for (int k = 0; k < nwin; k++) begin
      exp_d.push_back(win_of(k * s, p));
      exp_l.push_back(0);
    end
    b   = nwin * s;
    rem = n - b;
    if (pad != 0 && rem > 0 && (nwin == 0 || rem > p - s)) begin
      exp_d.push_back(win_of(b, rem));
      exp_l.push_back(1);
    end else if (nwin > 0) begin
      exp_l[nwin-1] = ((nwin - 1) * s + p == n) ? 1 : 2;
    end
  endtask

  task automatic wait_done(input string name, input bit no_win);
    bit ok = 1'b0;
    bit vld_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_vld) vld_seen = 1'b1;
      if (layer_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_cal);
    end
    chk(name, 64'(ok), 64'd1);
    if (no_win) chk({name, "_no_window"}, 64'(vld_seen), 64'd0);
  endtask

  task automatic run_layer(input int p, input int s, input int pad, input int n,
                           input int stall, input int rnd, input int base);
    int          idx = 0;
    int          cyc = 0;
    bit          le_sent = 1'b0, done = 1'b0, stalled = 1'b0, err_seen = 1'b0;
    logic [63:0] held = '0;
    sent_q.delete();
    for (int i = 0; i < n; i++) sent_q.push_back((rnd != 0) ? 8'($urandom) : 8'(base + i));
    build_exp(p, s, pad);
    got_d.delete();
    got_l.delete();
    @(negedge clk_cal);
    start = 1'b1; win_p = 4'(p); win_s = 3'(s); pad_en = 1'(pad);
    @(negedge clk_cal);
    start = 1'b0;
    while (cyc < 4000) begin
      if (layer_done) begin
        done = 1'b1;
        break;
      end
      if (cfg_err) err_seen = 1'b1;
      if (stalled) begin
        chk("hold_vld", 64'(out_vld), 64'd1);
        chk("hold_data", out_data, held);
      end
      if (stall > 0 && cyc == stall) begin
        chk("full_count", 64'(count), 64'(DEPTH));
        chk("full_in_rdy", 64'(in_rdy), 64'd0);
      end
      out_rdy = (cyc < stall) ? 1'b0 : ((rnd != 0) ? ($urandom % 4 != 0) : 1'b1);
      if (out_vld && out_rdy) begin
        got_d.push_back(out_data);
        got_l.push_back(out_last);
      end
      stalled = out_vld && !out_rdy;
      held    = out_data;
      in_vld = 1'b0;
      layer_end = 1'b0;
      if (!le_sent && in_rdy && (rnd == 0 || $urandom % 3 != 0)) begin
        if (idx < n) begin
          in_vld  = 1'b1;
          in_data = sent_q[idx];
          idx++;
        end
        if (idx == n) begin
          layer_end = 1'b1;
          le_sent   = 1'b1;
        end
      end
      // stray illegal start outside IDLE must be ignored
      start = (rnd != 0) && ($urandom % 16 == 0);
      win_p = 4'd0;
      cyc++;
      @(negedge clk_cal);
    end
    start = 1'b0; in_vld = 1'b0; layer_end = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL layer_timeout: P=%0d S=%0d n=%0d no layer_done", p, s, n);
    end
    chk("cfg_err_quiet", 64'(err_seen), 64'd0);
    chk("win_count", 64'(got_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      chk($sformatf("win%0d_data", i), got_d[i], exp_d[i]);
      if (exp_l[i] != 2) chk($sformatf("win%0d_last", i), 64'(got_l[i]), 64'(exp_l[i]));
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_vld"}, 64'(out_vld), 64'd0);
    chk({tag, "_out_data"}, out_data, 64'd0);
    chk({tag, "_out_last"}, 64'(out_last), 64'd0);
    chk({tag, "_layer_done"}, 64'(layer_done), 64'd0);
    chk({tag, "_cfg_err"}, 64'(cfg_err), 64'd0);
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_in_rdy"}, 64'(in_rdy), 64'd0);
  endtask

  cfg_vec_t vecs[8];

  initial begin
    rst_cal = 1'b1; start = 1'b0; win_p = '0; win_s = '0; pad_en = 1'b0;
    layer_end = 1'b0; in_data = '0; in_vld = 1'b0; out_rdy = 1'b0;
    repeat (2) @(negedge clk_cal);
    chk_zero_outputs("reset");
    rst_cal = 1'b0;

    vecs[0] = '{p: 4'd9,  s: 3'd1, err: 1'b1};
    vecs[1] = '{p: 4'd4,  s: 3'd0, err: 1'b1};
    vecs[2] = '{p: 4'd0,  s: 3'd1, err: 1'b1};
    vecs[3] = '{p: 4'd3,  s: 3'd4, err: 1'b1};
    vecs[4] = '{p: 4'd15, s: 3'd2, err: 1'b1};
    vecs[5] = '{p: 4'd8,  s: 3'd7, err: 1'b0};
    vecs[6] = '{p: 4'd1,  s: 3'd1, err: 1'b0};
    vecs[7] = '{p: 4'd5,  s: 3'd3, err: 1'b0};
    for (int v = 0; v < 8; v++) begin
      @(negedge clk_cal);
      start = 1'b1; win_p = vecs[v].p; win_s = vecs[v].s; pad_en = 1'b1;
      @(negedge clk_cal);
      start = 1'b0;
      chk($sformatf("cfg%0d_err", v), 64'(cfg_err), 64'(vecs[v].err));
      chk($sformatf("cfg%0d_in_rdy", v), 64'(in_rdy), 64'(!vecs[v].err));
      @(negedge clk_cal);
      chk($sformatf("cfg%0d_err_pulse", v), 64'(cfg_err), 64'd0);
      if (!vecs[v].err) begin
        layer_end = 1'b1;
        @(negedge clk_cal);
        layer_end = 1'b0;
        wait_done($sformatf("cfg%0d_empty_done", v), 1'b1);
      end
    end

    // Latency: window completes on the second byte and appears one edge later.
    @(negedge clk_cal);
    start = 1'b1; win_p = 4'd2; win_s = 3'd1; pad_en = 1'b0; out_rdy = 1'b1;
    @(negedge clk_cal);
    start = 1'b0; in_vld = 1'b1; in_data = 8'h11;
    @(negedge clk_cal);
    in_data = 8'h22;
    @(negedge clk_cal);
    in_vld = 1'b0;
    chk("lat_early", 64'(out_vld), 64'd0);
    @(negedge clk_cal);
    chk("lat_vld", 64'(out_vld), 64'd1);
    chk("lat_data", out_data, 64'h2211);
    chk("lat_last", 64'(out_last), 64'd0);
    layer_end = 1'b1;
    @(negedge clk_cal);
    layer_end = 1'b0;
    wait_done("lat_done", 1'b0);

    run_layer(4, 2, 0, 8, 0, 0, 1);
    chk("p4s2_w0", got_at(0), 64'h0403_0201);
    chk("p4s2_w1", got_at(1), 64'h0605_0403);
    chk("p4s2_w2", got_at(2), 64'h0807_0605);
    chk("p4s2_last", 64'((got_l.size() == 3) && got_l[2]), 64'd1);

    run_layer(8, 4, 1, 10, 0, 0, 1);
    chk("p8s4_w0", got_at(0), 64'h0807_0605_0403_0201);
    chk("p8s4_w1", got_at(1), 64'h0000_0a09_0807_0605);
    chk("p8s4_last", 64'((got_l.size() == 2) && got_l[1] && !got_l[0]), 64'd1);

    run_layer(2, 2, 0, 40, 50, 0, 1);
    chk("wrap_w0", got_at(0), 64'h0201);
    chk("wrap_w19", got_at(19), 64'h2827);

    // Reset while a window is stalled and 12 bytes remain buffered.
    @(negedge clk_cal);
    start = 1'b1; win_p = 4'd2; win_s = 3'd2; pad_en = 1'b0; out_rdy = 1'b0;
    @(negedge clk_cal);
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      in_vld = 1'b1;
      in_data = 8'(8'h50 + i);
      @(negedge clk_cal);
    end
    in_vld = 1'b0;
    chk("pre_rst_count", 64'(count), 64'd12);
    chk("pre_rst_vld", 64'(out_vld), 64'd1);
    #2 rst_cal = 1'b1;
    #1 chk_zero_outputs("midrst");
    @(negedge clk_cal);
    rst_cal = 1'b0;
    run_layer(3, 1, 1, 9, 0, 0, 8'h40);

    for (int t = 0; t < 12; t++) begin
      int p, s, pad, n;
      p   = int'($urandom_range(1, 8));
      s   = int'($urandom_range(1, p));
      pad = int'($urandom % 2);
      n   = int'($urandom_range(0, 45));
      run_layer(p, s, pad, n, 0, 1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
